audio_test_gen: RTL



---
 rtl/audio_test_gen_if.sv | 48 ++++
 rtl/audio_test_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/audio_test_gen_if.sv
// ============================================================================
// Module      : audio_test_gen_if
// Description : Control and live-audio FIFO push bundle for audio_test_gen.
//               master = controller / FIFO side, slave = generator side.
//               Optional macro AUDIO_TEST_GEN_ATTEN_EN adds the per-channel
//               attenuation input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_test_gen_if #(
  parameter int AUDIO_WIDTH = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
);
  logic                            enable;
  logic [1:0]                      mode;
  logic [CHANNELS*PHASE_WIDTH-1:0] freq_inc;
`ifdef AUDIO_TEST_GEN_ATTEN_EN
  logic [CHANNELS*4-1:0]           atten;
`endif
  logic [CHANNELS*AUDIO_WIDTH-1:0] sample_data;
  logic                            sample_en;
  logic                            sample_full;
  logic                            busy;

`ifdef AUDIO_TEST_GEN_ATTEN_EN
  modport master (
    output enable, mode, freq_inc, atten, sample_full,
    input  sample_data, sample_en, busy
  );
  modport slave (
    input  enable, mode, freq_inc, atten, sample_full,
    output sample_data, sample_en, busy
  );
`else
  modport master (
    output enable, mode, freq_inc, sample_full,
    input  sample_data, sample_en, busy
  );
  modport slave (
    input  enable, mode, freq_inc, sample_full,
    output sample_data, sample_en, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/audio_test_gen.sv
// ============================================================================
// Module      : audio_test_gen
// Description : Multi-channel audio test-signal generator. Per-channel NCO
//               phase accumulators feed one time-multiplexed waveform
//               datapath (SAW / SQUARE / TRIANGLE / SILENCE). Complete
//               frames are pushed to the live-audio FIFO via en/full.
//               Optional macro AUDIO_TEST_GEN_ATTEN_EN enables a per-channel
//               arithmetic right-shift attenuator ahead of staging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_test_gen #(
  parameter int AUDIO_WIDTH = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  audio_test_gen_if.slave   bus
);

  localparam int                    c_ch_w     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [c_ch_w-1:0]     c_last_ch  = c_ch_w'(CHANNELS - 1);
  localparam logic [1:0]            c_mode_saw = 2'd0;
  localparam logic [1:0]            c_mode_sq  = 2'd1;
  localparam logic [1:0]            c_mode_tri = 2'd2;
  localparam logic [AUDIO_WIDTH-1:0] c_neg_full = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
  localparam logic [AUDIO_WIDTH-1:0] c_pos_full = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [c_ch_w-1:0]               r_ch;
  logic [1:0]                      r_mode;
  logic [PHASE_WIDTH-1:0]          r_phase [CHANNELS];
  logic [AUDIO_WIDTH-1:0]          r_stage [CHANNELS];
  logic [CHANNELS*AUDIO_WIDTH-1:0] r_sample_data;
  logic                            r_sample_en;

  logic                            w_start;
  logic                            w_calc;
  logic                            w_push;
  logic                            w_last;
  logic [PHASE_WIDTH-1:0]          w_inc [CHANNELS];
  logic [CHANNELS*AUDIO_WIDTH-1:0] w_frame;
  logic [PHASE_WIDTH-1:0]          w_phase_cur;
  logic [PHASE_WIDTH-1:0]          w_inc_cur;
  logic [AUDIO_WIDTH-1:0]          w_p;
  logic [AUDIO_WIDTH-2:0]          w_tri_t;
  logic [AUDIO_WIDTH-1:0]          w_wave;
  logic [AUDIO_WIDTH-1:0]          w_staged;
`ifdef AUDIO_TEST_GEN_ATTEN_EN
  logic [3:0]                      w_att [CHANNELS];
`endif

  // Slot unpacking / frame packing: channel 0 lives in the most-significant slot
  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
      assign w_inc[g] = bus.freq_inc[(CHANNELS-1-g)*PHASE_WIDTH +: PHASE_WIDTH];
      assign w_frame[(CHANNELS-1-g)*AUDIO_WIDTH +: AUDIO_WIDTH] = r_stage[g];
`ifdef AUDIO_TEST_GEN_ATTEN_EN
      assign w_att[g] = bus.atten[(CHANNELS-1-g)*4 +: 4];
`endif
    end
  endgenerate

  assign w_last      = (r_ch == c_last_ch);
  assign w_phase_cur = r_phase[r_ch];
  assign w_inc_cur   = w_inc[r_ch];
  assign w_p         = w_phase_cur[PHASE_WIDTH-1 -: AUDIO_WIDTH];
  // Triangle folds the upper half of the phase back down so the ramp reverses
  assign w_tri_t     = w_p[AUDIO_WIDTH-1] ? ~w_p[AUDIO_WIDTH-2:0] : w_p[AUDIO_WIDTH-2:0];

  // Shared waveform datapath for the channel currently selected by r_ch
  always_comb begin
    w_wave = '0;
    case (r_mode)
      c_mode_saw: w_wave = w_p;
      c_mode_sq:  w_wave = w_p[AUDIO_WIDTH-1] ? c_neg_full : c_pos_full;
      c_mode_tri: w_wave = {w_tri_t, 1'b0} - c_neg_full;
      default:    w_wave = '0;
    endcase
  end

`ifdef AUDIO_TEST_GEN_ATTEN_EN
  assign w_staged = $signed(w_wave) >>> w_att[r_ch];
`else
  assign w_staged = w_wave;
`endif

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_calc      = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_start     = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc = 1'b1;
        if (w_last) begin
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (!bus.sample_full) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Channel counter and per-frame mode latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ch   <= '0;
      r_mode <= c_mode_saw;
    end else if (w_start) begin
      r_ch   <= '0;
      r_mode <= bus.mode;
    end else if (w_calc && !w_last) begin
      r_ch   <= r_ch + 1'b1;
    end
  end

  // Phase accumulation (silent wrap) and staging, one channel per CALC cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_phase[i] <= '0;
        r_stage[i] <= '0;
      end
    end else if (w_calc) begin
      r_phase[r_ch] <= w_phase_cur + w_inc_cur;
      r_stage[r_ch] <= w_staged;
    end
  end

  // Frame output: data only changes together with the one-cycle push strobe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sample_data <= '0;
      r_sample_en   <= 1'b0;
    end else begin
      r_sample_en <= w_push;
      if (w_push) begin
        r_sample_data <= w_frame;
      end
    end
  end

  assign bus.sample_data = r_sample_data;
  assign bus.sample_en   = r_sample_en;
  assign bus.busy        = (r_state != IDLE);

endmodule

`default_nettype wire
